// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state enum, the instruction width and the prefetch
// queue entry layout. Entry pc is sized for the widest supported XLEN (64);
// narrower builds zero-extend and the unused upper flops are constant.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_MAX = 64;
  typedef enum logic [1:0] {REQ, WAIT, DRAIN} fetch_state_t;
  typedef struct packed {
    logic [PC_MAX-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch queue with push/pop/flush and an occupancy count.
// Ports: clk, rst (sync, active-high); push/din write the tail; pop retires
// the head shown on dout; flush empties the queue; count = entries held
// (log2(DEPTH)+1 bits). Pointers are log2(DEPTH) bits and wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && count != (AW+1)'(DEPTH);
  assign do_pop = pop && count != '0;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a prefetch queue and redirect.
// Ports: clk, rst (sync, active-high); imem_req_* request channel (one
// request outstanding at most); imem_rsp_* response channel; redirect_* from
// execute; id_* valid/ready head of the prefetch queue toward decode.
// Optional macro FETCH_PERF_CNT_EN adds saturating perf_stall_cnt (cycles
// with id_ready & !id_valid) and perf_flush_cnt (redirect cycles).
// Supports XLEN from 32 up to 64.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [XLEN-1:0]    id_pc,
  output logic [INSTR_W-1:0] id_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  fetch_state_t state, state_nx;
  logic [XLEN-1:0] fetch_pc, req_pc;
  logic [AW:0] count;
  fetch_entry_t din, head;
  logic hs, push, outstanding, unused_bits;
  // Request is held off during reset so the first request appears in the
  // first cycle with rst low.
  assign imem_req_valid = !rst && state == REQ && count != (AW+1)'(DEPTH);
  assign imem_req_addr = fetch_pc;
  assign hs = imem_req_valid && imem_req_ready;
  // A redirect drops a same-cycle response; the flush empties the queue.
  assign push = state == WAIT && imem_rsp_valid && !redirect_valid;
  // A response arriving in this cycle retires the outstanding request.
  assign outstanding = state != REQ && !imem_rsp_valid;
  assign din = '{pc: PC_MAX'(req_pc), instr: imem_rsp_data};
  assign id_valid = count != '0;
  assign id_pc = head.pc[XLEN-1:0];
  assign id_instr = head.instr;
  assign unused_bits = ^{head.pc, redirect_pc[1:0]};
  always_comb begin
    state_nx = redirect_valid ? ((outstanding || hs) ? DRAIN : REQ) :
               state == REQ   ? (hs ? WAIT : REQ) :
               imem_rsp_valid ? REQ : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      fetch_pc <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state <= state_nx;
      if (redirect_valid) fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (hs) fetch_pc <= fetch_pc + XLEN'(4);
      if (hs) req_pc <= fetch_pc;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(id_valid && id_ready),
    .flush(redirect_valid),
    .din(din),
    .dout(head),
    .count(count)
  );
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (id_ready && !id_valid && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect_valid && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- XLEN, 32, PC/address width (≥32).
- DEPTH, 4, prefetch queue entries (power of 2, ≥2).
- RESET_PC, 0, fetch address after reset (word-aligned).
REQ-002 One clock; reset is synchronous and active-high. Ports (name, direction, width, meaning), one per line:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  instruction word returned.
- imem_rsp_data  in  32  returned instruction.
- redirect_valid  in  1  branch/jump redirect from execute.
- redirect_pc  in  XLEN  redirect target.
- id_valid  out  1  queue head valid to decode.
- id_ready  in  1  decode accepts head.
- id_pc  out  XLEN  PC of head instruction.
- id_instr  out  32  head instruction word.

Function
REQ-003 FSM states: REQ (imem_req_valid may assert), WAIT (one request outstanding), DRAIN (outstanding response to discard).
REQ-004 At most one memory request outstanding at any time.
REQ-005 In REQ: imem_req_valid = 1 iff queue count < DEPTH; imem_req_addr = fetch_pc.
REQ-006 Request handshake (valid & ready): go to WAIT; fetch_pc += 4, wrapping modulo 2^XLEN.
REQ-007 In WAIT: imem_rsp_valid pushes {pc, data} into queue tail, return to REQ; pushed pc = address of that request.
REQ-008 Response latency is arbitrary (≥1 cycle after accept); no timeout.
REQ-009 Pushed entry sets id_valid on the next cycle; no combinational bypass from imem_rsp to id_*.
REQ-010 Pop on id_valid & id_ready; push and pop in the same cycle leave count unchanged.
REQ-011 id_pc/id_instr stable while id_valid & !id_ready.
REQ-012 Redirect takes priority over all other events in its cycle:
- queue flushed (count = 0 next cycle);
- fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
- a same-cycle pop is consumed; a same-cycle push is dropped;
- next state DRAIN if a request is outstanding or is accepted this cycle, else REQ.
REQ-013 In DRAIN: imem_req_valid = 0; the response is discarded, then go to REQ; a response in the redirect cycle itself counts as that response.
REQ-014 A further redirect in DRAIN updates fetch_pc and stays in DRAIN.
REQ-015 imem_req_valid is never deasserted once asserted until handshake or redirect.

Reset
REQ-016 On rst: state REQ; fetch_pc = RESET_PC; queue empty; id_valid = 0; perf counters 0.
REQ-017 rst mid-request: any later response is not pushed. The memory must be reset with the block.
REQ-018 First imem_req_valid = 1 in the first cycle with rst = 0.

Configuration
REQ-019 Macro FETCH_PERF_CNT_EN:
- Defined: adds outputs perf_stall_cnt (out, 32; cycles with id_ready & !id_valid) and perf_flush_cnt (out, 32; redirect cycles), saturating at all-ones.
- Undefined: both ports and counters are absent.

Structure
REQ-020 Package fetch_pkg holds the state enum (REQ, WAIT, DRAIN), INSTR_W = 32, and the queue entry struct {pc, instr}.
REQ-021 Queue is sub-module fetch_fifo, parameters DEPTH and entry width, with push/pop/flush/count, log2(DEPTH)+1-bit count, and wrapping pointers.

Verification
REQ-022 Reset release, ready=1, rsp latency 1, id_ready=1 -> addresses 0x0, 0x4, 0x8…; id_pc matches; one instruction per 2 cycles.
REQ-023 id_ready=0, DEPTH=4 -> exactly 4 pushes, then imem_req_valid=0; release id_ready -> requests resume at 0x10.
REQ-024 Redirect to 0x103 while WAIT, rsp 3 cycles later -> rsp discarded, next request addr 0x100, first id_pc 0x100.
REQ-025 Redirect in the same cycle as rsp_valid and as a pop -> queue empty next cycle, rsp not pushed, state REQ.
REQ-026 fetch_pc = 0xFFFFFFFC handshake -> next addr 0x0.
REQ-027 With FETCH_PERF_CNT_EN: 3 redirects and 5 empty-ready cycles -> perf_flush_cnt = 3, perf_stall_cnt = 5.
